// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - stimulus/capture bundle between scanner and its controller
interface truth_table_scanner_if;
    logic       start;
    logic [7:0] exp;
    logic       y_in;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic [7:0] tbl;
    logic       match;
    logic [3:0] err_cnt;
    logic [2:0] err_idx;

    modport slave (
        input  start, exp, y_in,
        output a, b, c, busy, done, tbl, match, err_cnt, err_idx
    );

    modport master (
        output start, exp, y_in,
        input  a, b, c, busy, done, tbl, match, err_cnt, err_idx
    );
endinterface

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks a 3-input function through all codes and checks its truth table
module truth_table_scanner #(
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_exp, w_exp_nxt;
    logic [7:0] r_tbl, w_tbl_nxt;
    logic       r_match, w_match_nxt;
    logic [3:0] r_err_cnt, w_err_cnt_nxt;
    logic [2:0] r_err_idx, w_err_idx_nxt;
    logic [2:0] r_abc, w_abc_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic [7:0] w_tbl_cap;
    logic [7:0] w_diff;
    logic [3:0] w_pop;
    logic [2:0] w_first;

    // Table as it will be after the current capture, so the final compare sees bit 7.
    always_comb begin
        w_tbl_cap        = r_tbl;
        w_tbl_cap[r_idx] = bus.y_in;
        w_diff           = w_tbl_cap ^ r_exp;
        w_pop            = 4'd0;
        w_first          = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_pop   = w_pop + 4'd1;
                w_first = i[2:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_exp_nxt     = r_exp;
        w_tbl_nxt     = r_tbl;
        w_match_nxt   = r_match;
        w_err_cnt_nxt = r_err_cnt;
        w_err_idx_nxt = r_err_idx;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_exp_nxt     = bus.exp;
                    w_idx_nxt     = 3'd0;
                    w_tbl_nxt     = 8'h00;
                    w_cnt_nxt     = LP_RELOAD;
                    w_match_nxt   = 1'b0;
                    w_err_cnt_nxt = 4'd0;
                    w_err_idx_nxt = 3'd0;
                    w_state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                w_tbl_nxt = w_tbl_cap;
                if (r_idx == 3'd7) begin
                    w_match_nxt   = (w_diff == 8'h00);
                    w_err_cnt_nxt = w_pop;
                    w_err_idx_nxt = w_first;
                    w_state_nxt   = DONE;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_cnt_nxt   = LP_RELOAD;
                    w_state_nxt = DRIVE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_abc_nxt  = (w_state_nxt == DRIVE || w_state_nxt == SAMPLE) ? w_idx_nxt : 3'd0;
        w_busy_nxt = (w_state_nxt != IDLE);
        w_done_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= 3'd0;
            r_cnt     <= 4'd0;
            r_exp     <= 8'h00;
            r_tbl     <= 8'h00;
            r_match   <= 1'b0;
            r_err_cnt <= 4'd0;
            r_err_idx <= 3'd0;
            r_abc     <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_exp     <= w_exp_nxt;
            r_tbl     <= w_tbl_nxt;
            r_match   <= w_match_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_idx <= w_err_idx_nxt;
            r_abc     <= w_abc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.a       = r_abc[2];
    assign bus.b       = r_abc[1];
    assign bus.c       = r_abc[0];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.tbl     = r_tbl;
    assign bus.match   = r_match;
    assign bus.err_cnt = r_err_cnt;
    assign bus.err_idx = r_err_idx;
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed checks of truth_table_scanner at SETTLE=1 and SETTLE=3
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] func = 8'h54;
    logic       y1_stuck = 1'b0;
    logic       glitch3 = 1'b0;

    truth_table_scanner_if bus1();
    truth_table_scanner_if bus3();

    truth_table_scanner #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    truth_table_scanner #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Function block under test: minterms 2,4,6.
    assign bus1.y_in = y1_stuck | func[{bus1.a, bus1.b, bus1.c}];
    assign bus3.y_in = glitch3 ^ func[{bus3.a, bus3.b, bus3.c}];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic scan1(input logic [7:0] e, input int restart_at, input logic [7:0] e2,
                         output int done_edge, output int n_done,
                         output logic busy_at_done, output logic busy_after);
        done_edge    = -1;
        n_done       = 0;
        busy_at_done = 1'b0;
        busy_after   = 1'b1;
        bus1.start   = 1'b1;
        bus1.exp     = e;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        check("s1_busy_e0", bus1.busy, 1'b1);
        check("s1_abc_e0", {bus1.a, bus1.b, bus1.c}, 3'd0);
        for (int k = 1; k <= 24; k++) begin
            if (k == restart_at) begin
                bus1.start = 1'b1;
                bus1.exp   = e2;
            end
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            if (bus1.done) begin
                n_done++;
                if (done_edge < 0) begin
                    done_edge    = k;
                    busy_at_done = bus1.busy;
                end
            end
            if (done_edge >= 0 && k == done_edge + 1) busy_after = bus1.busy;
        end
    endtask

    initial begin
        int   de, nd, seen;
        logic bd, ba;
        bus1.start = 1'b0; bus1.exp = 8'h00;
        bus3.start = 1'b0; bus3.exp = 8'h00;
        #1;
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_done", bus1.done, 1'b0);
        check("rst_tbl", bus1.tbl, 8'h00);
        check("rst_match", bus1.match, 1'b0);
        check("rst_errs", {bus1.err_cnt, bus1.err_idx}, 7'd0);
        check("rst_abc", {bus1.a, bus1.b, bus1.c}, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Golden pass
        scan1(8'h54, 0, 8'h00, de, nd, bd, ba);
        check("gold_done_edge", de, 16);
        check("gold_n_done", nd, 1);
        check("gold_busy_at_done", bd, 1'b1);
        check("gold_busy_after", ba, 1'b0);
        check("gold_tbl", bus1.tbl, 8'h54);
        check("gold_match", bus1.match, 1'b1);
        check("gold_err_cnt", bus1.err_cnt, 4'd0);
        check("gold_err_idx", bus1.err_idx, 3'd0);

        // Single mismatch at bit 0
        scan1(8'h55, 0, 8'h00, de, nd, bd, ba);
        check("mm0_tbl", bus1.tbl, 8'h54);
        check("mm0_match", bus1.match, 1'b0);
        check("mm0_err_cnt", bus1.err_cnt, 4'd1);
        check("mm0_err_idx", bus1.err_idx, 3'd0);

        // Single mismatch at bit 2
        scan1(8'h50, 0, 8'h00, de, nd, bd, ba);
        check("mm2_err_cnt", bus1.err_cnt, 4'd1);
        check("mm2_err_idx", bus1.err_idx, 3'd2);

        // Stuck-at-1 output
        y1_stuck = 1'b1;
        scan1(8'h54, 0, 8'h00, de, nd, bd, ba);
        y1_stuck = 1'b0;
        check("sa1_tbl", bus1.tbl, 8'hFF);
        check("sa1_match", bus1.match, 1'b0);
        check("sa1_err_cnt", bus1.err_cnt, 4'd5);
        check("sa1_err_idx", bus1.err_idx, 3'd0);
        check("sa1_hold_idle", bus1.tbl, 8'hFF);

        // Start and exp change while busy are ignored
        scan1(8'h54, 5, 8'h00, de, nd, bd, ba);
        check("busy_done_edge", de, 16);
        check("busy_n_done", nd, 1);
        check("busy_match", bus1.match, 1'b1);
        check("busy_err_cnt", bus1.err_cnt, 4'd0);

        // Settle timing with glitches in the first DRIVE cycle of each code
        bus3.start = 1'b1;
        bus3.exp   = 8'h14;
        @(posedge clk);
        #1;
        bus3.start = 1'b0;
        glitch3    = 1'b1;
        de = -1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            glitch3 = ((k % 4) == 0) && (k < 32);
            if (bus3.done && de < 0) de = k;
            if (k == 3)  check("s3_abc_k3", {bus3.a, bus3.b, bus3.c}, 3'd0);
            if (k == 4)  check("s3_abc_k4", {bus3.a, bus3.b, bus3.c}, 3'd1);
            if (k == 31) check("s3_abc_k31", {bus3.a, bus3.b, bus3.c}, 3'd7);
            if (k == 32) check("s3_abc_done", {bus3.a, bus3.b, bus3.c}, 3'd0);
        end
        glitch3 = 1'b0;
        check("s3_done_edge", de, 32);
        check("s3_tbl", bus3.tbl, 8'h54);
        check("s3_err_cnt", bus3.err_cnt, 4'd1);
        check("s3_err_idx", bus3.err_idx, 3'd6);

        // Reset mid-scan at idx 4
        bus1.start = 1'b1;
        bus1.exp   = 8'h54;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            @(posedge clk);
            #1;
            if ({bus1.a, bus1.b, bus1.c} == 3'd4) seen = 1;
        end
        check("rm_reached_idx4", seen, 1);
        #3 rst = 1'b1;
        #1;
        check("rm_busy", bus1.busy, 1'b0);
        check("rm_abc", {bus1.a, bus1.b, bus1.c}, 3'd0);
        check("rm_tbl", bus1.tbl, 8'h00);
        check("rm_match", bus1.match, 1'b0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus1.done) seen = 1;
        end
        @(negedge clk) rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus1.done) seen = 1;
        end
        check("rm_no_done", seen, 0);
        scan1(8'h54, 0, 8'h00, de, nd, bd, ba);
        check("rm_rescan_edge", de, 16);
        check("rm_rescan_tbl", bus1.tbl, 8'h54);
        check("rm_rescan_match", bus1.match, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
